guess_game_engine: RTL and testbench

- Parametrised bulls-and-cows ("xAyB") game core for the keypad/seven-segment/dot-matrix guess-number board.
- Consumes debounced key events and holds a secret of NUM_DIGITS digits and the current guess.
- Scores each guess sequentially (exact-position "A" hits, wrong-position "B" hits), then tracks attempts and win/lose.
- Sits between the keypad scanner and the display drivers; the displays read its entry buffer, scores and status.

---
 rtl/guess_pkg.sv | 24 ++
 rtl/guess_scorer.sv | 96 +++++++++
 rtl/guess_game_engine.sv | 208 ++++++++++++++++++++
 tb/tb_guess_game_engine.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/guess_pkg.sv
// Shared definitions for the bulls-and-cows game core.
//   KEY_*       : keypad codes with a special meaning (digits are 0-9)
//   phase_e     : game phase encoding, also driven on the phase output
//   count_width : bits needed to hold a count from 0 to n inclusive
package guess_pkg;

    localparam logic [3:0] KEY_ENTER   = 4'hA;
    localparam logic [3:0] KEY_BACK    = 4'hB;
    localparam logic [3:0] KEY_RESTART = 4'hF;

    typedef enum logic [2:0] {
        PH_SET_SECRET = 3'd0,
        PH_GUESS      = 3'd1,
        PH_COMPARE    = 3'd2,
        PH_RESULT     = 3'd3,
        PH_WIN        = 3'd4,
        PH_LOSE       = 3'd5
    } phase_e;

    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/guess_scorer.sv
// Iterative A/B scorer: one guess digit per cycle against the whole secret.
//   clk, rst      : clock, asynchronous active-low reset
//   clear         : synchronous abort, returns to idle with cleared accumulators
//   start         : begin scoring; secret/guess must be stable from the next cycle
//   secret, guess : NUM_DIGITS packed digits, slot i = [4i+3:4i]
//   busy          : scoring in progress (one cycle per digit)
//   done          : one-cycle pulse on the last step; a/b are final while done=1
//   a, b          : exact-position hits, wrong-position hits
module guess_scorer
    import guess_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clear,
    input  logic                                start,
    input  logic [4*NUM_DIGITS-1:0]             secret,
    input  logic [4*NUM_DIGITS-1:0]             guess,
    output logic                                busy,
    output logic                                done,
    output logic [count_width(NUM_DIGITS)-1:0]  a,
    output logic [count_width(NUM_DIGITS)-1:0]  b
);

    localparam int            CW   = count_width(NUM_DIGITS);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);

    logic          busy_q, busy_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] a_acc_q, a_acc_d;
    logic [CW-1:0] b_acc_q, b_acc_d;

    logic [3:0]    g_dig;
    logic [CW-1:0] step_a, step_b, a_sum, b_sum;
    logic          last;

    always_comb begin
        g_dig  = guess[32'(idx_q)*4 +: 4];
        step_a = (g_dig == secret[32'(idx_q)*4 +: 4]) ? ONE : '0;
        step_b = '0;
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            if ((j != 32'(idx_q)) && (secret[j*4 +: 4] == g_dig))
                step_b = step_b + ONE;
        end
        a_sum = a_acc_q + step_a;
        b_sum = b_acc_q + step_b;
        last  = (idx_q == LAST);
    end

    // Final scores include the current step so the parent can load them on
    // the same edge that ends the last compare cycle.
    assign busy = busy_q;
    assign done = busy_q && last;
    assign a    = a_sum;
    assign b    = b_sum;

    always_comb begin
        busy_d  = busy_q;
        idx_d   = idx_q;
        a_acc_d = a_acc_q;
        b_acc_d = b_acc_q;
        if (clear) begin
            busy_d  = 1'b0;
            idx_d   = '0;
            a_acc_d = '0;
            b_acc_d = '0;
        end else if (start) begin
            busy_d  = 1'b1;
            idx_d   = '0;
            a_acc_d = '0;
            b_acc_d = '0;
        end else if (busy_q) begin
            a_acc_d = a_sum;
            b_acc_d = b_sum;
            if (last) busy_d = 1'b0;
            else      idx_d  = idx_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q  <= 1'b0;
            idx_q   <= '0;
            a_acc_q <= '0;
            b_acc_q <= '0;
        end else begin
            busy_q  <= busy_d;
            idx_q   <= idx_d;
            a_acc_q <= a_acc_d;
            b_acc_q <= b_acc_d;
        end
    end

endmodule

// File: rtl/guess_game_engine.sv
// Bulls-and-cows ("xAyB") game core: entry buffer, phase FSM, attempt count.
//   clk, rst          : clock, asynchronous active-low reset
//   key_valid/code    : debounced key strobe; 0-9 digit, A enter, B backspace,
//                       F restart, other codes ignored
//   entry_buf/cnt     : digits being typed (slot 0 = first typed) and count
//   phase             : guess_pkg::phase_e value
//   a_cnt/b_cnt       : last score, updated with a one-cycle result_valid
//   tries             : guesses scored since restart (saturating)
//   key_reject        : one-cycle pulse when a key is refused
//   win/lose          : decoded from phase
module guess_game_engine
    import guess_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int MAX_TRIES  = 10,
    parameter bit UNIQUE     = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                key_valid,
    input  logic [3:0]                          key_code,
    output logic [4*NUM_DIGITS-1:0]             entry_buf,
    output logic [count_width(NUM_DIGITS)-1:0]  entry_cnt,
    output logic [2:0]                          phase,
    output logic [count_width(NUM_DIGITS)-1:0]  a_cnt,
    output logic [count_width(NUM_DIGITS)-1:0]  b_cnt,
    output logic                                result_valid,
    output logic [7:0]                          tries,
    output logic                                key_reject,
    output logic                                win,
    output logic                                lose
);

    localparam int            CW   = count_width(NUM_DIGITS);
    localparam int            BW   = 4 * NUM_DIGITS;
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] FULL = CW'(NUM_DIGITS);

    phase_e        phase_q, phase_d;
    logic [BW-1:0] entry_q, entry_d;
    logic [BW-1:0] secret_q, secret_d;
    logic [BW-1:0] guess_q, guess_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] a_q, a_d;
    logic [CW-1:0] b_q, b_d;
    logic [7:0]    tries_q, tries_d;
    logic          rv_q, rv_d;
    logic          rej_q, rej_d;

    logic          restart, is_digit, full, dup;
    logic          score_start, score_busy, score_done;
    logic [CW-1:0] score_a, score_b;

    guess_scorer #(
        .NUM_DIGITS(NUM_DIGITS)
    ) u_scorer (
        .clk    (clk),
        .rst    (rst),
        .clear  (restart),
        .start  (score_start),
        .secret (secret_q),
        .guess  (guess_q),
        .busy   (score_busy),
        .done   (score_done),
        .a      (score_a),
        .b      (score_b)
    );

    always_comb begin
        restart  = key_valid && (key_code == KEY_RESTART);
        is_digit = (key_code <= 4'd9);
        full     = (cnt_q == FULL);
        dup      = 1'b0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if ((k < 32'(cnt_q)) && (entry_q[k*4 +: 4] == key_code))
                dup = 1'b1;
        end
    end

    always_comb begin
        phase_d     = phase_q;
        entry_d     = entry_q;
        secret_d    = secret_q;
        guess_d     = guess_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        tries_d     = tries_q;
        rv_d        = 1'b0;
        rej_d       = 1'b0;
        score_start = 1'b0;

        if (restart) begin
            phase_d  = PH_SET_SECRET;
            entry_d  = '0;
            secret_d = '0;
            guess_d  = '0;
            cnt_d    = '0;
            a_d      = '0;
            b_d      = '0;
            tries_d  = '0;
        end else begin
            unique case (phase_q)
                PH_SET_SECRET, PH_GUESS: begin
                    if (key_valid) begin
                        if (is_digit) begin
                            if (full || (UNIQUE && dup)) begin
                                rej_d = 1'b1;
                            end else begin
                                entry_d[32'(cnt_q)*4 +: 4] = key_code;
                                cnt_d = cnt_q + ONE;
                            end
                        end else if (key_code == KEY_BACK) begin
                            if (cnt_q == '0) begin
                                rej_d = 1'b1;
                            end else begin
                                entry_d[(32'(cnt_q)-1)*4 +: 4] = '0;
                                cnt_d = cnt_q - ONE;
                            end
                        end else if (key_code == KEY_ENTER) begin
                            if (!full) begin
                                rej_d = 1'b1;
                            end else begin
                                entry_d = '0;
                                cnt_d   = '0;
                                if (phase_q == PH_SET_SECRET) begin
                                    secret_d = entry_q;
                                    phase_d  = PH_GUESS;
                                end else begin
                                    guess_d     = entry_q;
                                    score_start = 1'b1;
                                    phase_d     = PH_COMPARE;
                                end
                            end
                        end
                    end
                end
                PH_COMPARE: begin
                    rej_d = key_valid;
                    if (score_done) begin
                        a_d     = score_a;
                        b_d     = score_b;
                        rv_d    = 1'b1;
                        tries_d = (tries_q == 8'hFF) ? tries_q : tries_q + 8'd1;
                        phase_d = PH_RESULT;
                    end else if (!score_busy) begin
                        // Scorer idle without finishing: never expected, recover to entry.
                        phase_d = PH_GUESS;
                    end
                end
                PH_RESULT: begin
                    rej_d = key_valid;
                    // tries_q already holds the incremented count here; WIN checked first.
                    if (a_q == FULL)
                        phase_d = PH_WIN;
                    else if ((MAX_TRIES != 0) && (32'(tries_q) == MAX_TRIES))
                        phase_d = PH_LOSE;
                    else
                        phase_d = PH_GUESS;
                end
                PH_WIN, PH_LOSE: begin
                    rej_d = key_valid;
                end
                default: begin
                    phase_d = PH_SET_SECRET;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q  <= PH_SET_SECRET;
            entry_q  <= '0;
            secret_q <= '0;
            guess_q  <= '0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            tries_q  <= '0;
            rv_q     <= 1'b0;
            rej_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            entry_q  <= entry_d;
            secret_q <= secret_d;
            guess_q  <= guess_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            tries_q  <= tries_d;
            rv_q     <= rv_d;
            rej_q    <= rej_d;
        end
    end

    assign entry_buf    = entry_q;
    assign entry_cnt    = cnt_q;
    assign phase        = phase_q;
    assign a_cnt        = a_q;
    assign b_cnt        = b_q;
    assign result_valid = rv_q;
    assign tries        = tries_q;
    assign key_reject   = rej_q;
    assign win          = (phase_q == PH_WIN);
    assign lose         = (phase_q == PH_LOSE);

endmodule

// File: tb/tb_guess_game_engine.sv
module tb_guess_game_engine;

    typedef struct {
        int a;
        int b;
        int tries;
        int ph_next;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic       kv [3];
    logic [3:0] kc [3];

    logic [23:0] eb [3];
    logic [2:0]  cnt [3];
    logic [2:0]  ph [3];
    logic [2:0]  ac [3];
    logic [2:0]  bc [3];
    logic        rv [3];
    logic [7:0]  tr [3];
    logic        rj [3];
    logic        wn [3];
    logic        ls [3];

    logic [15:0] eb_u0, eb_u1;
    logic [23:0] eb_u2;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   tries_m [3];
    exp_t sb [$];

    always #5 clk = ~clk;

    // 0: NUM_DIGITS=4, MAX_TRIES=10, UNIQUE=1
    guess_game_engine #(.NUM_DIGITS(4), .MAX_TRIES(10), .UNIQUE(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .key_valid(kv[0]), .key_code(kc[0]),
        .entry_buf(eb_u0), .entry_cnt(cnt[0]), .phase(ph[0]), .a_cnt(ac[0]),
        .b_cnt(bc[0]), .result_valid(rv[0]), .tries(tr[0]), .key_reject(rj[0]),
        .win(wn[0]), .lose(ls[0]));

    // 1: NUM_DIGITS=4, MAX_TRIES=2, UNIQUE=1
    guess_game_engine #(.NUM_DIGITS(4), .MAX_TRIES(2), .UNIQUE(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .key_valid(kv[1]), .key_code(kc[1]),
        .entry_buf(eb_u1), .entry_cnt(cnt[1]), .phase(ph[1]), .a_cnt(ac[1]),
        .b_cnt(bc[1]), .result_valid(rv[1]), .tries(tr[1]), .key_reject(rj[1]),
        .win(wn[1]), .lose(ls[1]));

    // 2: NUM_DIGITS=6, MAX_TRIES=10, UNIQUE=1
    guess_game_engine #(.NUM_DIGITS(6), .MAX_TRIES(10), .UNIQUE(1'b1)) u_dut2 (
        .clk(clk), .rst(rst), .key_valid(kv[2]), .key_code(kc[2]),
        .entry_buf(eb_u2), .entry_cnt(cnt[2]), .phase(ph[2]), .a_cnt(ac[2]),
        .b_cnt(bc[2]), .result_valid(rv[2]), .tries(tr[2]), .key_reject(rj[2]),
        .win(wn[2]), .lose(ls[2]));

    assign eb[0] = {8'h00, eb_u0};
    assign eb[1] = {8'h00, eb_u1};
    assign eb[2] = eb_u2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge; returns on the next negedge with the key registered.
    task automatic press(input int d, input logic [3:0] code);
        kc[d] = code;
        kv[d] = 1'b1;
        @(negedge clk);
        kv[d] = 1'b0;
        kc[d] = 4'h0;
    endtask

    // v holds n digits, most significant nibble typed first.
    function automatic logic [3:0] dig(input logic [31:0] v, input int n, input int i);
        logic [31:0] t;
        t = v >> (4 * (n - 1 - i));
        return t[3:0];
    endfunction

    task automatic type_num(input int d, input int n, input logic [31:0] v);
        for (int i = 0; i < n; i++) press(d, dig(v, n, i));
    endtask

    task automatic set_secret(input int d, input int n, input logic [31:0] v);
        type_num(d, n, v);
        press(d, 4'hA);
    endtask

    // Enter a guess, push the model's expectation, wait for the result pulse.
    task automatic do_guess(input int d, input int n, input int max_t,
                            input logic [31:0] sec, input logic [31:0] g, input string tag);
        exp_t e;
        exp_t got;
        int   k;
        e.a = 0;
        e.b = 0;
        for (int i = 0; i < n; i++) begin
            if (dig(g, n, i) == dig(sec, n, i)) e.a++;
            for (int j = 0; j < n; j++)
                if (j != i && dig(g, n, i) == dig(sec, n, j)) e.b++;
        end
        if (tries_m[d] < 255) tries_m[d]++;
        e.tries   = tries_m[d];
        e.ph_next = (e.a == n) ? 4 : ((max_t != 0 && e.tries == max_t) ? 5 : 1);
        type_num(d, n, g);
        sb.push_back(e);
        press(d, 4'hA);
        chk({tag, "_cmp_phase"}, 32'(ph[d]), 2);
        k = 1;
        while (!rv[d] && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_latency"}, k, n + 1);
        got = sb.pop_front();
        chk({tag, "_a"}, 32'(ac[d]), got.a);
        chk({tag, "_b"}, 32'(bc[d]), got.b);
        chk({tag, "_tries"}, 32'(tr[d]), got.tries);
        chk({tag, "_res_phase"}, 32'(ph[d]), 3);
        @(negedge clk);
        chk({tag, "_rv_drop"}, 32'(rv[d]), 0);
        chk({tag, "_next_phase"}, 32'(ph[d]), got.ph_next);
        chk({tag, "_win"}, 32'(wn[d]), (got.ph_next == 4) ? 1 : 0);
        chk({tag, "_lose"}, 32'(ls[d]), (got.ph_next == 5) ? 1 : 0);
    endtask

    initial begin
        int rv_seen;
        for (int i = 0; i < 3; i++) begin
            kv[i] = 1'b0;
            kc[i] = 4'h0;
            tries_m[i] = 0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_phase", 32'(ph[0]), 0);
        chk("rst_eb", eb[0], 0);
        chk("rst_cnt", 32'(cnt[0]), 0);
        chk("rst_ab", {ac[0], bc[0]}, 0);
        chk("rst_tries", 32'(tr[0]), 0);
        chk("rst_flags", {rv[0], rj[0], wn[0], ls[0]}, 0);

        // Entry rules on instance 0
        press(0, 4'h1);
        chk("dig1_rej", 32'(rj[0]), 0);
        press(0, 4'h1);
        chk("dup_rej", 32'(rj[0]), 1);
        chk("dup_cnt", 32'(cnt[0]), 1);
        press(0, 4'hB);
        chk("bs1_rej", 32'(rj[0]), 0);
        chk("bs1_cnt", 32'(cnt[0]), 0);
        press(0, 4'hB);
        chk("bs_empty_rej", 32'(rj[0]), 1);
        type_num(0, 3, 32'h123);
        chk("eb_123", eb[0], 32'h0321);
        press(0, 4'hA);
        chk("short_enter_rej", 32'(rj[0]), 1);
        chk("short_enter_phase", 32'(ph[0]), 0);
        press(0, 4'h4);
        press(0, 4'hA);
        chk("secret_phase", 32'(ph[0]), 1);
        chk("secret_clr", {8'h0, eb[0], 5'h0, cnt[0]}, 0);

        do_guess(0, 4, 10, 32'h1234, 32'h1243, "g1243");
        type_num(0, 4, 32'h5678);
        press(0, 4'h9);
        chk("full_rej", 32'(rj[0]), 1);
        chk("full_eb", eb[0], 32'h8765);
        // Remove the typed guess again so do_guess types it cleanly.
        for (int i = 0; i < 4; i++) press(0, 4'hB);
        do_guess(0, 4, 10, 32'h1234, 32'h5678, "g5678");
        do_guess(0, 4, 10, 32'h1234, 32'h1234, "g1234");
        press(0, 4'h5);
        chk("win_key_rej", 32'(rj[0]), 1);
        chk("win_sticky", 32'(ph[0]), 4);
        press(0, 4'hF);
        chk("restart_phase", 32'(ph[0]), 0);
        chk("restart_tries", 32'(tr[0]), 0);
        chk("restart_win", 32'(wn[0]), 0);

        // MAX_TRIES=2 on instance 1
        set_secret(1, 4, 32'h1234);
        do_guess(1, 4, 2, 32'h1234, 32'h5678, "m2_g1");
        do_guess(1, 4, 2, 32'h1234, 32'h8765, "m2_g2");
        press(1, 4'h3);
        chk("lose_key_rej", 32'(rj[1]), 1);
        chk("lose_sticky", 32'(ls[1]), 1);
        press(1, 4'hF);
        tries_m[1] = 0;
        chk("lose_restart", 32'(ph[1]), 0);
        set_secret(1, 4, 32'h1234);
        do_guess(1, 4, 2, 32'h1234, 32'h5678, "m2w_g1");
        do_guess(1, 4, 2, 32'h1234, 32'h1234, "m2w_g2");
        press(1, 4'hF);
        tries_m[1] = 0;

        // Restart during the second compare cycle
        set_secret(1, 4, 32'h1234);
        do_guess(1, 4, 2, 32'h1234, 32'h1243, "pre_abort");
        type_num(1, 4, 32'h5678);
        press(1, 4'hA);
        press(1, 4'h7);
        chk("cmp_key_rej", 32'(rj[1]), 1);
        press(1, 4'hF);
        tries_m[1] = 0;
        chk("abort_phase", 32'(ph[1]), 0);
        chk("abort_tries", 32'(tr[1]), 0);
        chk("abort_ab", {ac[1], bc[1]}, 0);
        chk("abort_entry", {eb[1], 5'h0, cnt[1]}, 0);
        rv_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (rv[1]) rv_seen++;
            @(negedge clk);
        end
        chk("abort_no_rv", rv_seen, 0);

        // NUM_DIGITS=6 on instance 2
        set_secret(2, 6, 32'h123456);
        do_guess(2, 6, 10, 32'h123456, 32'h654321, "n6");
        type_num(2, 2, 32'h12);
        chk("n6_eb", eb[2], 32'h000021);
        #2;
        rst = 1'b0;
        #1;
        chk("async_eb", eb[2], 0);
        chk("async_cnt", 32'(cnt[2]), 0);
        chk("async_phase", 32'(ph[2]), 0);
        chk("async_tries", 32'(tr[2]), 0);
        chk("async_ab", {ac[2], bc[2]}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
